// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the binary32 FPU blocks: field widths, bias, the
// canonical quiet NaN, a packed view of a binary32 word and operand-class
// decode helpers. Subnormal encodings (exp == 0) are treated as zero.
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == '1) && (x.man != '0);
  endfunction

  function automatic logic is_inf(input fp32_t x);
    return (x.exp == '1) && (x.man == '0);
  endfunction

  // exp == 0 covers true zeros and flushed subnormals alike.
  function automatic logic is_zero(input fp32_t x);
    return x.exp == '0;
  endfunction

endpackage

// File: rtl/fp_normalize.sv
// ---------------------------------------------------------------------------
// fp_normalize
// Normalizes the 28-bit mantissa sum of the adder so that the hidden one
// lands in bit 26 of a 27-bit {1.man, G, R, S} word, and adjusts the exponent.
// Ports:
//   sum     [27:0]  raw sum/difference of the aligned mantissas (bit 27 = carry)
//   exp_in  [9:0]   signed exponent of the larger operand
//   mant    [26:0]  normalized mantissa with guard, round, sticky in [2:0]
//   exp_out [9:0]   signed adjusted exponent (may leave the 1..254 range)
// A zero sum is handled by the caller; the count here is then meaningless.
// ---------------------------------------------------------------------------
module fp_normalize (
  input  logic        [27:0] sum,
  input  logic signed [9:0]  exp_in,
  output logic        [26:0] mant,
  output logic signed [9:0]  exp_out
);

  logic [4:0] lzc;
  logic       found;

  // Leading-zero count over the non-carry part of the sum.
  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lzc   = 5'(26 - i);
      end
    end
  end

  always_comb begin
    if (sum[27]) begin
      // Carry-out: one right shift, the dropped bit folds into sticky.
      mant    = {sum[27:2], sum[1] | sum[0]};
      exp_out = exp_in + 10'sd1;
    end else begin
      mant    = sum[26:0] << lzc;
      exp_out = exp_in - $signed({5'd0, lzc});
    end
  end

endmodule

// File: rtl/fp13_add_sub.sv
// ---------------------------------------------------------------------------
// fp13_add_sub
// Combinational binary32 adder/subtractor: c = a + b (op=0) or a - b (op=1).
// Round-to-nearest-even, subnormals flushed to zero on input and output.
// Ports:
//   clk   clock, present for interface uniformity only
//   rst   asynchronous active-low reset, present for interface uniformity only
//   op    0 = add, 1 = subtract (inverts b's sign)
//   a, b  operands {sign, exp[7:0], man[22:0]}
//   c     result, same layout; pure function of {a, b, op}
// ---------------------------------------------------------------------------
module fp13_add_sub
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);

  // clk/rst intentionally reach no logic; the result path is stateless.
  logic unused_ports;
  assign unused_ports = &{1'b0, clk, rst};

  fp32_t fa, fb;
  assign fa = a;
  assign fb = b;

  logic sign_b;
  assign sign_b = fb.sign ^ op;

  // Magnitude ordering: swap when b is strictly larger.
  logic swap;
  assign swap = {fb.exp, fb.man} > {fa.exp, fa.man};

  logic        sign_l;
  logic [7:0]  exp_l, exp_s, diff;
  logic [23:0] man_l, man_s;

  assign sign_l = swap ? sign_b : fa.sign;
  assign exp_l  = swap ? fb.exp : fa.exp;
  assign exp_s  = swap ? fa.exp : fb.exp;
  assign man_l  = swap ? {1'b1, fb.man} : {1'b1, fa.man};
  assign man_s  = swap ? {1'b1, fa.man} : {1'b1, fb.man};
  assign diff   = exp_l - exp_s;

  // Alignment: shift the smaller mantissa inside a wide window so every
  // bit that falls below the round position can be OR-ed into sticky.
  logic [49:0] shift_full;
  logic [26:0] aligned_l, aligned_s;

  assign shift_full = {man_s, 26'd0} >> diff;
  assign aligned_l  = {man_l, 3'b000};
  assign aligned_s  = (diff >= 8'd26) ? 27'd1
                                      : {shift_full[49:24], |shift_full[23:0]};

  logic        eff_sub;
  logic [27:0] sum;

  assign eff_sub = fa.sign ^ sign_b;
  // aligned_l >= aligned_s always holds, so the difference never wraps.
  assign sum = eff_sub ? ({1'b0, aligned_l} - {1'b0, aligned_s})
                       : ({1'b0, aligned_l} + {1'b0, aligned_s});

  logic        [26:0] norm_mant;
  logic signed [9:0]  norm_exp;

  fp_normalize u_normalize (
    .sum     (sum),
    .exp_in  ($signed({2'b00, exp_l})),
    .mant    (norm_mant),
    .exp_out (norm_exp)
  );

  // Round to nearest, ties to even.
  logic        round_up, round_ovf;
  logic [24:0] rounded;
  logic [22:0] res_man;
  logic signed [9:0] res_exp;

  assign round_up  = norm_mant[2] & (norm_mant[1] | norm_mant[0] | norm_mant[3]);
  assign rounded   = {1'b0, norm_mant[26:3]} + {24'd0, round_up};
  assign round_ovf = rounded[24];
  assign res_man   = round_ovf ? rounded[23:1] : rounded[22:0];
  assign res_exp   = norm_exp + $signed({9'd0, round_ovf});

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = is_nan(fa);
  assign b_nan  = is_nan(fb);
  assign a_inf  = is_inf(fa);
  assign b_inf  = is_inf(fb);
  assign a_zero = is_zero(fa);
  assign b_zero = is_zero(fb);

  always_comb begin
    c = {sign_l, res_exp[7:0], res_man};
    if (a_nan || b_nan) begin
      c = FP_QNAN;
    end else if (a_inf && b_inf) begin
      c = (fa.sign != sign_b) ? FP_QNAN : {fa.sign, 8'hFF, 23'd0};
    end else if (a_inf) begin
      c = {fa.sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      c = {sign_b, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      // Only (-0)+(-0) keeps a negative sign.
      c = {fa.sign & sign_b, 31'd0};
    end else if (a_zero) begin
      c = {sign_b, fb.exp, fb.man};
    end else if (b_zero) begin
      c = a;
    end else if (sum == 28'd0) begin
      c = 32'd0;
    end else if (res_exp >= 10'sd255) begin
      c = {sign_l, 8'hFF, 23'd0};
    end else if (res_exp <= 10'sd0) begin
      c = {sign_l, 31'd0};
    end
  end

endmodule

// File: tb/tb_fp13_add_sub.sv
// ---------------------------------------------------------------------------
// tb_fp13_add_sub
// Table of directed vectors, a static-clock/reset-held sequence, then random
// operands checked against an exact-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp13_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op  = 1'b0;
  logic [31:0] a   = 32'd0;
  logic [31:0] b   = 32'd0;
  logic [31:0] c;
  bit          clk_run = 1'b1;

  int checks = 0;
  int errors = 0;

  fp13_add_sub dut (
    .clk (clk),
    .rst (rst),
    .op  (op),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] expv;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: c=%08h expected %08h", name, got, expv);
    end
  endtask

  // Exact reference: scale both operands onto a common integer grid, add
  // with unbounded precision, then round the exact result to 24 bits.
  function automatic logic [31:0] ref_model(input logic [31:0] xa, input logic [31:0] xb,
                                            input logic xop);
    logic sa, sb, sr;
    int ea, eb, emin, p, sh, be;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [299:0] va, vb, mag, kept, rem, half;
    sa = xa[31];
    sb = xb[31] ^ xop;
    ea = int'(xa[30:23]);
    eb = int'(xb[30:23]);
    a_nan  = (ea == 255) && (xa[22:0] != 0);
    b_nan  = (eb == 255) && (xb[22:0] != 0);
    a_inf  = (ea == 255) && (xa[22:0] == 0);
    b_inf  = (eb == 255) && (xb[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return 32'h7FC00000;
    if (a_inf && b_inf) return (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
    if (a_inf) return {sa, 8'hFF, 23'd0};
    if (b_inf) return {sb, 8'hFF, 23'd0};
    if (a_zero && b_zero) return {sa & sb, 31'd0};
    if (a_zero) return {sb, xb[30:0]};
    if (b_zero) return xa;
    emin = (ea < eb) ? ea : eb;
    va = 300'({1'b1, xa[22:0]}) << (ea - emin);
    vb = 300'({1'b1, xb[22:0]}) << (eb - emin);
    if (sa == sb) begin
      mag = va + vb; sr = sa;
    end else if (va >= vb) begin
      mag = va - vb; sr = sa;
    end else begin
      mag = vb - va; sr = sb;
    end
    if (mag == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag - (kept << sh);
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    end else begin
      kept = mag << (23 - p);
    end
    be = p + emin - 23;
    if (kept[24]) begin
      kept = kept >> 1;
      be++;
    end
    if (be >= 255) return {sr, 8'hFF, 23'd0};
    if (be <= 0) return {sr, 31'd0};
    return {sr, 8'(be), kept[22:0]};
  endfunction

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
    vecs[2]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000};
    vecs[3]  = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000};
    vecs[4]  = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000};
    vecs[5]  = '{32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000};
    vecs[6]  = '{32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000};
    vecs[7]  = '{32'hBF800000, 32'hBF800000, 1'b1, 32'h00000000};
    vecs[8]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
    vecs[9]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};
    vecs[10] = '{32'h40400000, 32'h3F000000, 1'b0, 32'h40600000};
    vecs[11] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000};
    vecs[12] = '{32'h40000000, 32'h3FFFFFFF, 1'b1, 32'h34000000};
    vecs[13] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};
    vecs[15] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000};
    vecs[16] = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000000};
    vecs[17] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000};
    vecs[18] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[19] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000};
    vecs[20] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000};
    vecs[21] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000};
    vecs[22] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000};

    // Reset asserted at start, then released.
    rst = 1'b0;
    #12;
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      a  = vecs[i].a;
      b  = vecs[i].b;
      op = vecs[i].op;
      #1;
      $display("vec %0d: a=%08h b=%08h op=%0d c=%08h exp=%08h", i, a, b, op, c, vecs[i].expv);
      check($sformatf("vec%0d", i), c, vecs[i].expv);
    end

    // Reset held low and clock stopped: the result must still track inputs.
    @(negedge clk);
    clk_run = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a  = vecs[i].a;
      b  = vecs[i].b;
      op = vecs[i].op;
      #1;
      check($sformatf("static%0d", i), c, vecs[i].expv);
      #20;
      $display("static %0d: a=%08h b=%08h op=%0d c=%08h exp=%08h", i, a, b, op, c, vecs[i].expv);
      check($sformatf("static_hold%0d", i), c, vecs[i].expv);
    end
    rst     = 1'b1;
    clk_run = 1'b1;

    // Random operands, biased toward close exponents and near-cancellation.
    for (int n = 0; n < 1000; n++) begin
      int mode, ea_i, eb_i, off;
      logic [31:0] ra, rb, expv;
      logic        rop;
      mode = int'($urandom_range(0, 9));
      ra   = $urandom;
      rb   = $urandom;
      rop  = 1'($urandom);
      ea_i = int'($urandom_range(1, 254));
      if (mode < 6) begin
        off  = int'($urandom_range(0, 60)) - 30;
        eb_i = ea_i + off;
        if (eb_i < 1) eb_i = 1;
        if (eb_i > 254) eb_i = 254;
        ra[30:23] = 8'(ea_i);
        rb[30:23] = 8'(eb_i);
      end else if (mode == 6) begin
        ra[30:23] = 8'(ea_i);
        rb[30:23] = 8'(ea_i);
        rb[22:0]  = ra[22:0] ^ 23'($urandom_range(0, 15));
        rb[31]    = ra[31] ^ ~rop;
      end else if (mode == 7) begin
        ra[30:23] = 8'(ea_i);
        if ($urandom_range(0, 1) == 0) rb[30:23] = 8'h00;
        else                            rb[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) rb[22:0] = 23'd0;
      end
      @(negedge clk);
      a  = ra;
      b  = rb;
      op = rop;
      #1;
      expv = ref_model(ra, rb, rop);
      $display("rand %0d: a=%08h b=%08h op=%0d c=%08h exp=%08h", n, ra, rb, rop, c, expv);
      check($sformatf("rand%0d", n), c, expv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
